// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI mode-0 target for the 16-bit {rd_wr, addr, data} frame, backed by a local register file.
// Rev 1.0 -- all logic in the mclk domain; sclk/cs/mosi are oversampled through synchronizers.
`timescale 1ns/1ps
`default_nettype none

module spi_target_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic       addr_err,
  input  logic [6:0] host_addr,
  output logic [7:0] host_rdata
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic addr_ok(input logic [6:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  hdr_q, hdr_d, hdr_next;
  logic [7:0]  rx_q, rx_d, rx_next;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic        addr_err_q, addr_err_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  // Sync chains reset low so a cs already held low at reset release is not seen as a new frame.
  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign hdr_next = {hdr_q[6:0], mosi_s};
  assign rx_next  = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    hdr_d        = hdr_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    addr_err_d   = 1'b0;
    regs_d       = regs_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = HEADER;
          bit_cnt_d = 5'd0;
        end
      end
      HEADER: begin
        if (cs_s) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          hdr_d     = hdr_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            state_d = DATA;
            // Read data is frozen here; later writes do not affect this frame.
            if (hdr_next[7] && addr_ok(hdr_next[6:0]))
              tx_d = regs_q[hdr_next[AW-1:0]];
            else
              tx_d = 8'h00;
          end
        end
      end
      DATA: begin
        if (cs_s) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          if (sclk_fall && hdr_q[7]) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (!hdr_q[7])
              rx_d = rx_next;
            if (bit_cnt_q == 5'd15) begin
              state_d      = DONE;
              miso_d       = 1'b0;
              frame_done_d = 1'b1;
              addr_err_d   = ~addr_ok(hdr_q[6:0]);
              if (!hdr_q[7] && addr_ok(hdr_q[6:0])) begin
                regs_d[hdr_q[AW-1:0]] = rx_next;
                wr_valid_d            = 1'b1;
                wr_addr_d             = hdr_q[6:0];
                wr_data_d             = rx_next;
              end
            end
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_s)
          state_d = IDLE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= 5'd0;
      hdr_q        <= 8'h00;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      miso_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= 7'h00;
      wr_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= 8'h00;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      hdr_q        <= hdr_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      addr_err_q   <= addr_err_d;
      regs_q       <= regs_d;
    end
  end

  assign miso       = miso_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign addr_err   = addr_err_q;
  assign host_rdata = addr_ok(host_addr) ? regs_q[host_addr[AW-1:0]] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: directed SPI frames; pulse events and read bytes are checked by a scoreboard monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_target_regfile;

  localparam int NUM_REGS = 16;
  localparam int HALF     = 6;   // mclk cycles per sclk half period

  logic       mclk = 1'b0;
  logic       reset, sclk, cs, mosi;
  logic       miso, wr_valid, frame_done, frame_err, addr_err;
  logic [6:0] wr_addr, host_addr;
  logic [7:0] wr_data, host_rdata;

  spi_target_regfile #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .mclk(mclk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .addr_err(addr_err),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic       wv;
    logic [6:0] a;
    logic [7:0] d;
    logic       fd;
    logic       fe;
    logic       ae;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] got_rd_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [NUM_REGS];
  logic [7:0] rd;
  logic       mo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic wv, input logic [6:0] a, input logic [7:0] d,
                         input logic fd, input logic fe, input logic ae);
    ev_t e;
    e = '{wv: wv, a: a, d: d, fd: fd, fe: fe, ae: ae};
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, {27'd0, miso, wr_valid, frame_done, frame_err, addr_err}, 32'd0);
    check({tag, "_wr_addr"}, {25'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = 7'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), {24'd0, host_rdata}, {24'd0, model[i]});
    end
    host_addr = 7'h40;
    #1;
    check({tag, "_reg_oob"}, {24'd0, host_rdata}, 32'd0);
  endtask

  // Master side of one frame; nr sclk rises, optional cs release at the end.
  task automatic frame(input logic [7:0] h, input logic [7:0] d, input int nr, input bit raise_cs,
                       output logic [7:0] rdo, output logic mor);
    logic [15:0] w;
    w   = {h, d};
    rdo = 8'h00;
    mor = 1'b0;
    @(negedge mclk);
    cs = 1'b0;
    repeat (HALF) @(negedge mclk);
    for (int i = 0; i < nr; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      repeat (HALF) @(negedge mclk);
      sclk = 1'b1;
      if (i >= 8 && i < 16) rdo = {rdo[6:0], miso};
      mor = mor | miso;
      repeat (HALF) @(negedge mclk);
      sclk = 1'b0;
    end
    if (raise_cs) begin
      repeat (HALF) @(negedge mclk);
      cs = 1'b1;
      repeat (2 * HALF) @(negedge mclk);
    end
  endtask

  // Scoreboard monitor: every pulse cycle consumes one expected event.
  initial begin : monitor
    ev_t        e;
    logic [7:0] er, gr;
    forever begin
      @(negedge mclk);
      if (!reset && (wr_valid || frame_done || frame_err || addr_err)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got wv=%0b fd=%0b fe=%0b ae=%0b expected none",
                   wr_valid, frame_done, frame_err, addr_err);
        end else begin
          e = exp_q.pop_front();
          if ({wr_valid, frame_done, frame_err, addr_err} !== {e.wv, e.fd, e.fe, e.ae} ||
              (e.wv && (wr_addr !== e.a || wr_data !== e.d))) begin
            errors++;
            $display("FAIL pulse_event: got wv=%0b a=%0h d=%0h fd=%0b fe=%0b ae=%0b expected wv=%0b a=%0h d=%0h fd=%0b fe=%0b ae=%0b",
                     wr_valid, wr_addr, wr_data, frame_done, frame_err, addr_err,
                     e.wv, e.a, e.d, e.fd, e.fe, e.ae);
          end
        end
      end
      if (got_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
        gr = got_rd_q.pop_front();
        er = exp_rd_q.pop_front();
        checks++;
        if (gr !== er) begin
          errors++;
          $display("FAIL miso_read: got %0h expected %0h", gr, er);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; host_addr = 7'h00;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    repeat (4) @(negedge mclk);
    check_outputs_zero("reset");
    check_regs("reset");
    @(negedge mclk);
    reset = 1'b0;
    repeat (10) @(negedge mclk);

    // Basic write
    push_ev(1'b1, 7'h05, 8'hA5, 1'b1, 1'b0, 1'b0);
    model[5] = 8'hA5;
    frame(8'h05, 8'hA5, 16, 1'b1, rd, mo);
    check("wr05_miso_low", {31'd0, mo}, 32'd0);
    check("wr05_wr_addr_held", {25'd0, wr_addr}, 32'h05);
    check("wr05_wr_data_held", {24'd0, wr_data}, 32'hA5);
    host_addr = 7'h05; #1;
    check("wr05_host", {24'd0, host_rdata}, 32'hA5);

    // Write then read back over miso
    push_ev(1'b1, 7'h02, 8'h3C, 1'b1, 1'b0, 1'b0);
    model[2] = 8'h3C;
    frame(8'h02, 8'h3C, 16, 1'b1, rd, mo);
    push_ev(1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_rd_q.push_back(8'h3C);
    frame(8'h82, 8'h00, 16, 1'b1, rd, mo);
    got_rd_q.push_back(rd);

    // Out-of-range address: write is dropped, read returns zero
    push_ev(1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    frame(8'h40, 8'h77, 16, 1'b1, rd, mo);
    check_regs("oob_wr");
    push_ev(1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    exp_rd_q.push_back(8'h00);
    frame(8'hC0, 8'h00, 16, 1'b1, rd, mo);
    got_rd_q.push_back(rd);

    // Abort after 11 rises, then a normal frame
    push_ev(1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    frame(8'h03, 8'h99, 11, 1'b1, rd, mo);
    host_addr = 7'h03; #1;
    check("abort_reg3", {24'd0, host_rdata}, 32'h00);
    push_ev(1'b1, 7'h03, 8'h5A, 1'b1, 1'b0, 1'b0);
    model[3] = 8'h5A;
    frame(8'h03, 8'h5A, 16, 1'b1, rd, mo);
    host_addr = 7'h03; #1;
    check("after_abort_reg3", {24'd0, host_rdata}, 32'h5A);

    // 20 sclk cycles under one cs: one frame only
    push_ev(1'b1, 7'h01, 8'h11, 1'b1, 1'b0, 1'b0);
    model[1] = 8'h11;
    frame(8'h01, 8'h11, 20, 1'b1, rd, mo);
    check("long_cs_miso_low", {31'd0, mo}, 32'd0);
    check_regs("long_cs");

    // Reset at rise 12 of a write to addr 4
    frame(8'h04, 8'hFF, 12, 1'b0, rd, mo);
    @(negedge mclk);
    reset = 1'b1;
    #2;
    check_outputs_zero("midreset");
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    check_regs("midreset");
    cs = 1'b1;
    repeat (5) @(negedge mclk);
    reset = 1'b0;
    repeat (30) @(negedge mclk);
    check_outputs_zero("post_reset");
    check_regs("post_reset");

    repeat (5) @(negedge mclk);
    check("scoreboard_drained", 32'(exp_q.size() + exp_rd_q.size() + got_rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
